// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types
// Types shared by the UART receiver and the matching transmitter.
//   rx_state_t : receiver FSM states
//   parity_t   : parity sense (even / odd)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_t;

endpackage

// File: rtl/uart_rx_stream_if.sv
// rtl/uart_rx_stream_if.sv - received-word stream interface
// Carries received words from the UART receiver to a consumer.
//   data_out   : received word, LSB = first data bit on the line
//   data_valid : word and status valid, held until accepted
//   data_ready : consumer accepts when data_valid && data_ready
//   frame_err  : stop bit sampled 0 for the presented word
//   parity_err : parity mismatch for the presented word
//   overrun    : sticky, a completed frame was dropped
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_stream_if #(
  parameter int DATA_BITS = 16
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out, data_valid, frame_err, parity_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, frame_err, parity_err, overrun,
    output data_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period timer with mid-bit and end-of-period ticks
// Free-running counter 0..CYCLE_DIV-1, held at 0 while clear is high.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count at 0 on the next cycle
//   half_tick : count == CYCLE_DIV/2-1
//   full_tick : count == CYCLE_DIV-1 (wraps to 0 afterwards)
module uart_bit_timer #(
  parameter int CYCLE_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = $clog2(CYCLE_DIV);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == TW'(CYCLE_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign half_tick = (cnt == TW'(CYCLE_DIV / 2 - 1));
  assign full_tick = (cnt == TW'(CYCLE_DIV - 1));

endmodule

// File: rtl/uart_rx_stream.sv
// rtl/uart_rx_stream.sv - UART receiver with valid/ready word output
// Finds each frame from its start bit, samples mid-bit, assembles DATA_BITS
// LSB-first and presents the word with framing/parity status.
// Optional parity bit: define UART_RX_PARITY_EN.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   rx_in  : asynchronous serial line, idle high
//   rx_bus : uart_rx_stream_if.master (data_out, data_valid, data_ready,
//            frame_err, parity_err, overrun)
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int CYCLE_DIV  = 100,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  uart_rx_stream_if.master  rx_bus
);

  localparam int IW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam parity_t PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 wait_high;
  logic                 half_tick;
  logic                 full_tick;
  logic                 timer_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Timer sits at 0 while idle; restarting it at mid-start-bit makes every
  // later full_tick land in the middle of a bit.
  assign timer_clr = (state == IDLE) || ((state == START) && half_tick);

  uart_bit_timer #(
    .CYCLE_DIV (CYCLE_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      shift_reg         <= '0;
      par_bad           <= 1'b0;
      wait_high         <= 1'b0;
      rx_bus.data_out   <= '0;
      rx_bus.data_valid <= 1'b0;
      rx_bus.frame_err  <= 1'b0;
      rx_bus.parity_err <= 1'b0;
      rx_bus.overrun    <= 1'b0;
    end else begin
      if (rx_bus.data_valid && rx_bus.data_ready) begin
        rx_bus.data_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // After a low stop bit (e.g. break) the line must go high again
          // before a new falling edge can count as a start bit.
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (half_tick) begin
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (full_tick) begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (idx == IW'(i)) shift_reg[i] <= rx_s;
            end
            if (idx == IW'(DATA_BITS - 1)) begin
              idx   <= '0;
              state <= PAR_EN ? PARITY : STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        PARITY: begin
          if (full_tick) begin
            par_bad <= rx_s ^ (^shift_reg) ^ 1'(PAR_SENSE);
            state   <= STOP;
          end
        end
        STOP: begin
          if (full_tick) begin
            state     <= IDLE;
            wait_high <= ~rx_s;
            // Output slot is free if empty or being accepted this very cycle.
            if (!rx_bus.data_valid || rx_bus.data_ready) begin
              rx_bus.data_out   <= shift_reg;
              rx_bus.frame_err  <= ~rx_s;
              rx_bus.parity_err <= PAR_EN & par_bad;
              rx_bus.data_valid <= 1'b1;
            end else begin
              rx_bus.overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
